// File: rtl/tqvp_gera_gray_pkg.sv
// Shared constants for the Gray engine peripheral: register map, CTRL bit positions, converter mode.
package tqvp_gera_gray_pkg;

    localparam logic [3:0] ADDR_CTRL     = 4'h0;
    localparam logic [3:0] ADDR_OPERAND0 = 4'h1;
    localparam logic [3:0] ADDR_RESULT0  = 4'h5;
    localparam logic [3:0] ADDR_SNAP0    = 4'h9;
    localparam logic [3:0] ADDR_DIV      = 4'hD;

    localparam int CTRL_START    = 0;
    localparam int CTRL_MODE     = 1;
    localparam int CTRL_CNT_EN   = 2;
    localparam int CTRL_DIR      = 3;
    localparam int CTRL_CLEAR    = 4;
    localparam int CTRL_EXT_TICK = 5;
    localparam int CTRL_SNAP     = 6;

    typedef enum logic {
        MODE_BIN2GRAY = 1'b0,
        MODE_GRAY2BIN = 1'b1
    } conv_mode_e;

endpackage

// File: rtl/tqvp_gera_gray_serial.sv
// Bit-serial binary<->Gray converter, MSB first, one bit per clock.
// done_pulse and result are valid together in the final busy cycle.
module tqvp_gera_gray_serial
    import tqvp_gera_gray_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done_pulse,
    output logic [WIDTH-1:0] result
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-2:0] acc_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             busy_reg;
    logic             prev_in_reg;
    logic             prev_out_reg;
    conv_mode_e       mode_reg;

    logic bit_in;
    logic bit_out;
    logic last_bit;

    // prev_* start at 0, so the MSB passes through unchanged in both modes
    assign bit_in     = shift_reg[WIDTH-1];
    assign bit_out    = (mode_reg == MODE_GRAY2BIN) ? (prev_out_reg ^ bit_in)
                                                    : (prev_in_reg ^ bit_in);
    assign last_bit   = busy_reg && (idx_reg == '0);
    assign result     = {acc_reg, bit_out};
    assign busy       = busy_reg;
    assign done_pulse = last_bit && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg    <= '0;
            acc_reg      <= '0;
            idx_reg      <= '0;
            busy_reg     <= 1'b0;
            prev_in_reg  <= 1'b0;
            prev_out_reg <= 1'b0;
            mode_reg     <= MODE_BIN2GRAY;
        end else if (abort) begin
            busy_reg <= 1'b0;
        end else if (start && !busy_reg) begin
            shift_reg    <= operand;
            mode_reg     <= conv_mode_e'(mode);
            prev_in_reg  <= 1'b0;
            prev_out_reg <= 1'b0;
            idx_reg      <= IDX_W'(WIDTH - 1);
            busy_reg     <= 1'b1;
        end else if (busy_reg) begin
            shift_reg    <= shift_reg << 1;
            acc_reg      <= result[WIDTH-2:0];
            prev_in_reg  <= bit_in;
            prev_out_reg <= bit_out;
            idx_reg      <= idx_reg - IDX_W'(1);
            if (last_bit) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tqvp_gera_gray_engine.sv
// TinyQV peripheral: serial Gray converter plus Gray up/down counter with prescaler and snapshot.
// Optional macro GRAY_ENG_EXT_TICK_EN: counter ticks from synchronised rising edges of ui_in[0].
module tqvp_gera_gray_engine
    import tqvp_gera_gray_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int NBYTES = WIDTH / 8;

    logic [7:0]       operand_bytes_reg [NBYTES];
    logic [WIDTH-1:0] operand_vec;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] snap_reg;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] gray_vec;
    logic [7:0]       div_reg;
    logic [7:0]       presc_reg;
    logic             mode_reg;
    logic             cnt_en_reg;
    logic             dir_reg;
    logic             done_reg;
    logic             ext_tick_bit;

    logic             wr_ctrl;
    logic             start_req;
    logic             start_accept;
    logic             clear_req;
    logic             snap_req;
    logic             conv_busy;
    logic             conv_done;
    logic [WIDTH-1:0] conv_result;
    logic             presc_tick;
    logic             presc_run;
    logic             tick;
    logic [7:0]       rd_data;

    logic [7:0] opnd_rd   [4];
    logic [7:0] result_rd [4];
    logic [7:0] snap_rd   [4];

    assign wr_ctrl      = data_write && (address == ADDR_CTRL);
    assign clear_req    = wr_ctrl && data_in[CTRL_CLEAR];
    assign start_req    = wr_ctrl && data_in[CTRL_START] && !data_in[CTRL_CLEAR];
    assign start_accept = start_req && !conv_busy;
    assign snap_req     = wr_ctrl && data_in[CTRL_SNAP];

    assign gray_vec   = cnt_reg ^ (cnt_reg >> 1);
    assign uo_out     = gray_vec[7:0];
    assign presc_tick = cnt_en_reg && (presc_reg >= div_reg);

    tqvp_gera_gray_serial #(.WIDTH(WIDTH)) u_serial (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_req),
        .abort      (clear_req),
        .mode       (data_in[CTRL_MODE]),
        .operand    (operand_vec),
        .busy       (conv_busy),
        .done_pulse (conv_done),
        .result     (conv_result)
    );

`ifdef GRAY_ENG_EXT_TICK_EN
    logic [2:0] sync_reg;
    logic       ext_tick_reg;
    logic       ext_rise;
    logic       unused_sink;

    assign ext_rise     = sync_reg[1] && !sync_reg[2];
    assign ext_tick_bit = ext_tick_reg;
    assign tick         = ext_tick_reg ? (cnt_en_reg && ext_rise) : presc_tick;
    assign presc_run    = cnt_en_reg && !ext_tick_reg;
    assign unused_sink  = ^{ui_in[7:1], data_in[7]};

    // two synchroniser flops, the third one only remembers the previous level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg     <= '0;
            ext_tick_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[1:0], ui_in[0]};
            if (wr_ctrl) begin
                ext_tick_reg <= data_in[CTRL_EXT_TICK];
            end
        end
    end
`else
    logic unused_sink;

    assign ext_tick_bit = 1'b0;
    assign tick         = presc_tick;
    assign presc_run    = cnt_en_reg;
    assign unused_sink  = ^{ui_in, data_in[7], data_in[CTRL_EXT_TICK]};
`endif

    always_comb begin
        operand_vec = '0;
        for (int k = 0; k < NBYTES; k++) begin
            operand_vec[k*8 +: 8] = operand_bytes_reg[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NBYTES; k++) begin
                operand_bytes_reg[k] <= '0;
            end
            div_reg    <= '0;
            mode_reg   <= 1'b0;
            cnt_en_reg <= 1'b0;
            dir_reg    <= 1'b0;
        end else begin
            for (int k = 0; k < NBYTES; k++) begin
                if (data_write && (address == 4'(ADDR_OPERAND0 + k))) begin
                    operand_bytes_reg[k] <= data_in;
                end
            end
            if (data_write && (address == ADDR_DIV)) begin
                div_reg <= data_in;
            end
            if (wr_ctrl) begin
                mode_reg   <= data_in[CTRL_MODE];
                cnt_en_reg <= data_in[CTRL_CNT_EN];
                dir_reg    <= data_in[CTRL_DIR];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else if (clear_req) begin
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else if (start_accept) begin
            done_reg <= 1'b0;
        end else if (conv_done) begin
            result_reg <= conv_result;
            done_reg   <= 1'b1;
        end
    end

    // snapshot samples gray_vec before this cycle's tick lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            presc_reg <= '0;
            snap_reg  <= '0;
        end else if (clear_req) begin
            cnt_reg   <= '0;
            presc_reg <= '0;
            snap_reg  <= '0;
        end else begin
            if (presc_run) begin
                presc_reg <= presc_tick ? 8'h00 : presc_reg + 8'h01;
            end
            if (tick) begin
                cnt_reg <= dir_reg ? cnt_reg - WIDTH'(1) : cnt_reg + WIDTH'(1);
            end
            if (snap_req) begin
                snap_reg <= gray_vec;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            if (gi < NBYTES) begin : g_live
                assign opnd_rd[gi]   = operand_bytes_reg[gi];
                assign result_rd[gi] = result_reg[gi*8 +: 8];
                assign snap_rd[gi]   = snap_reg[gi*8 +: 8];
            end else begin : g_pad
                assign opnd_rd[gi]   = 8'h00;
                assign result_rd[gi] = 8'h00;
                assign snap_rd[gi]   = 8'h00;
            end
        end
    endgenerate

    always_comb begin
        rd_data = 8'h00;
        if (address == ADDR_CTRL) begin
            rd_data = {2'b00, ext_tick_bit, dir_reg, cnt_en_reg, mode_reg, done_reg, conv_busy};
        end else if (address == ADDR_DIV) begin
            rd_data = div_reg;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (address == 4'(ADDR_OPERAND0 + k)) rd_data = opnd_rd[k];
                if (address == 4'(ADDR_RESULT0 + k))  rd_data = result_rd[k];
                if (address == 4'(ADDR_SNAP0 + k))    rd_data = snap_rd[k];
            end
        end
    end

    assign data_out = rd_data;

endmodule

// File: tb/tb_tqvp_gera_gray_engine.sv
// Self-checking bench for tqvp_gera_gray_engine (WIDTH=16): register vectors, directed
// converter/counter/clear/reset sequences, and randomized runs against a reference model.
module tb_tqvp_gera_gray_engine;

    localparam int W = 16;

    localparam logic [3:0] A_CTRL = 4'h0;
    localparam logic [3:0] A_OP0  = 4'h1;
    localparam logic [3:0] A_RES0 = 4'h5;
    localparam logic [3:0] A_SNP0 = 4'h9;
    localparam logic [3:0] A_DIV  = 4'hD;

    localparam logic [7:0] C_START = 8'h01;
    localparam logic [7:0] C_MODE  = 8'h02;
    localparam logic [7:0] C_EN    = 8'h04;
    localparam logic [7:0] C_DIR   = 8'h08;
    localparam logic [7:0] C_CLEAR = 8'h10;
    localparam logic [7:0] C_SNAP  = 8'h40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       do_wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [12];

    tqvp_gera_gray_engine #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    always #50 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [15:0] to_gray(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [15:0] from_gray(input logic [15:0] g);
        logic [15:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(posedge clk);
        #1;
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        address = a;
        #1;
        v = data_out;
    endtask

    task automatic rd16(input logic [3:0] a, output logic [15:0] v);
        logic [7:0] lo;
        logic [7:0] hi;
        rd(a, lo);
        rd(4'(a + 4'd1), hi);
        v = {hi, lo};
    endtask

    // counts cycles from 'first' while CTRL.busy reads 1, bounded
    task automatic wait_idle(input int first, output int cycles);
        logic [7:0] v;
        cycles = first;
        for (int c = 0; c < 40; c++) begin
            rd(A_CTRL, v);
            if (!v[0]) break;
            step(1);
            cycles++;
        end
    endtask

    task automatic run_conv(input logic [15:0] op, input logic mode, output logic [15:0] res,
                            output int cycles);
        wr(A_OP0, op[7:0]);
        wr(4'(A_OP0 + 4'd1), op[15:8]);
        wr(A_CTRL, C_START | (mode ? C_MODE : 8'h00));
        wait_idle(0, cycles);
        rd16(A_RES0, res);
    endtask

    initial begin
        logic [7:0]  v;
        logic [15:0] v16;
        logic [15:0] exp16;
        int          cyc;
        logic [7:0]  ext_exp;

`ifdef GRAY_ENG_EXT_TICK_EN
        ext_exp = 8'h20;
`else
        ext_exp = 8'h00;
`endif
        vecs[0]  = '{1'b1, A_DIV,  8'h5A, 8'h5A};
        vecs[1]  = '{1'b1, 4'h1,   8'h34, 8'h34};
        vecs[2]  = '{1'b1, 4'h2,   8'h12, 8'h12};
        vecs[3]  = '{1'b1, 4'h3,   8'hAB, 8'h00};
        vecs[4]  = '{1'b1, 4'h4,   8'hCD, 8'h00};
        vecs[5]  = '{1'b1, 4'hE,   8'h77, 8'h00};
        vecs[6]  = '{1'b1, 4'hF,   8'h77, 8'h00};
        vecs[7]  = '{1'b1, A_RES0, 8'hFF, 8'h00};
        vecs[8]  = '{1'b1, A_SNP0, 8'hFF, 8'h00};
        vecs[9]  = '{1'b1, A_CTRL, 8'h1A, 8'h14};
        vecs[10] = '{1'b1, A_CTRL, 8'h20, ext_exp};
        vecs[11] = '{1'b1, A_DIV,  8'h00, 8'h00};

        // reset state
        @(posedge clk);
        #1;
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), v);
            check($sformatf("reset_rd_%0d", a), v, 8'h00);
        end
        check("reset_uo_out", uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, v);
            $display("vec %0d addr=%h wdata=%h read=%h want=%h", i, vecs[i].addr, vecs[i].wdata,
                     v, vecs[i].exp);
            check($sformatf("vec_%0d", i), v, vecs[i].exp);
        end
        wr(A_CTRL, 8'h00);

        // bin->gray 0x1234, busy exactly 16 cycles, RESULT held mid-run
        wr(A_OP0, 8'h34);
        wr(4'(A_OP0 + 4'd1), 8'h12);
        wr(A_CTRL, C_START);
        step(8);
        rd16(A_RES0, v16);
        check("b2g_result_held", v16, 16'h0000);
        wait_idle(8, cyc);
        check("b2g_busy_cycles", cyc, 16);
        rd16(A_RES0, v16);
        check("b2g_result", v16, 16'h1B2E);
        rd(A_CTRL, v);
        check("b2g_ctrl_done", v, 8'h02);
        $display("conv b2g op=1234 result=%h cycles=%0d", v16, cyc);

        // gray->bin with ignored second START and operand change at cycle 5
        wr(A_OP0, 8'h2E);
        wr(4'(A_OP0 + 4'd1), 8'h1B);
        wr(A_CTRL, C_START | C_MODE);
        rd(A_CTRL, v);
        check("g2b_busy_done_cleared", v, 8'h05);
        step(4);
        wr(A_CTRL, C_START | C_MODE);
        wr(A_OP0, 8'hFF);
        wait_idle(6, cyc);
        check("g2b_busy_cycles", cyc, 16);
        rd16(A_RES0, v16);
        check("g2b_result", v16, 16'h1234);
        step(3);
        rd(A_CTRL, v);
        check("g2b_no_restart", v, 8'h06);
        $display("conv g2b op=1B2E result=%h cycles=%0d", v16, cyc);

        // counter up, DIV=0, snapshot after 5 ticks
        wr(A_CTRL, C_EN);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            exp16 = to_gray(16'(k));
            check($sformatf("up_uo_out_%0d", k), uo_out, exp16[7:0]);
        end
        wr(A_CTRL, C_EN | C_SNAP);
        rd16(A_SNP0, v16);
        check("up_snapshot", v16, 16'h0007);
        $display("count up snapshot=%h uo_out=%h", v16, uo_out);
        wr(A_CTRL, 8'h00);

        // counter down from cleared state with DIV=3: wrap to 0xFFFF
        wr(A_CTRL, C_CLEAR);
        wr(A_DIV, 8'h03);
        wr(A_CTRL, C_EN | C_DIR);
        step(3);
        check("down_pretick_uo_out", uo_out, 8'h00);
        rd16(A_SNP0, v16);
        check("down_snapshot_cleared", v16, 16'h0000);
        step(1);
        wr(A_CTRL, C_EN | C_DIR | C_SNAP);
        rd16(A_SNP0, v16);
        check("down_snapshot_wrap", v16, 16'h8000);
        check("down_uo_out_wrap", uo_out, 8'h00);
        $display("count down snapshot=%h uo_out=%h", v16, uo_out);
        wr(A_CTRL, 8'h00);

        // CLEAR|START during a running conversion
        wr(A_OP0, 8'h55);
        wr(4'(A_OP0 + 4'd1), 8'hAA);
        wr(A_CTRL, C_START);
        step(4);
        wr(A_CTRL, C_CLEAR | C_START);
        rd(A_CTRL, v);
        check("clr_ctrl", v, 8'h00);
        rd16(A_RES0, v16);
        check("clr_result", v16, 16'h0000);
        rd16(A_SNP0, v16);
        check("clr_snapshot", v16, 16'h0000);
        step(20);
        rd(A_CTRL, v);
        check("clr_no_new_conv", v, 8'h00);
        rd16(A_RES0, v16);
        check("clr_result_later", v16, 16'h0000);
        wr(A_CTRL, C_SNAP);
        rd16(A_SNP0, v16);
        check("clr_cnt_zero", v16, 16'h0000);
        $display("clear during conversion ctrl=%h snapshot=%h", v, v16);

        // asynchronous reset mid-conversion and mid-count
        wr(A_DIV, 8'h01);
        wr(A_CTRL, C_EN);
        wr(A_CTRL, C_EN | C_START);
        step(5);
        #5;
        rst_n = 1'b0;
        #1;
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), v);
            check($sformatf("arst_rd_%0d", a), v, 8'h00);
        end
        check("arst_uo_out", uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        run_conv(16'h1234, 1'b0, v16, cyc);
        check("arst_after_cycles", cyc, 16);
        check("arst_after_result", v16, 16'h1B2E);
        $display("after reset conv result=%h cycles=%0d", v16, cyc);

        // randomized conversions against the reference model
        for (int it = 0; it < 12; it++) begin
            logic [15:0] op;
            logic        md;
            op = 16'($urandom);
            md = 1'($urandom_range(0, 1));
            exp16 = md ? from_gray(op) : to_gray(op);
            run_conv(op, md, v16, cyc);
            $display("rand conv %0d op=%h mode=%0d result=%h want=%h cycles=%0d", it, op, md,
                     v16, exp16, cyc);
            check($sformatf("rconv_cycles_%0d", it), cyc, 16);
            check($sformatf("rconv_result_%0d", it), v16, exp16);
        end

        // randomized counter runs: ticks = enabled cycles / (DIV+1)
        for (int it = 0; it < 12; it++) begin
            int          d;
            int          n;
            logic        dir;
            logic [15:0] val;
            d   = $urandom_range(0, 7);
            n   = $urandom_range(0, 40);
            dir = 1'($urandom_range(0, 1));
            wr(A_DIV, 8'(d));
            wr(A_CTRL, C_CLEAR | C_EN | (dir ? C_DIR : 8'h00));
            step(n);
            wr(A_CTRL, C_EN | C_SNAP | (dir ? C_DIR : 8'h00));
            val = 16'(n / (d + 1));
            if (dir) val = 16'(0) - val;
            exp16 = to_gray(val);
            rd16(A_SNP0, v16);
            $display("rand count %0d div=%0d n=%0d dir=%0d snapshot=%h want=%h", it, d, n, dir,
                     v16, exp16);
            check($sformatf("rcnt_snapshot_%0d", it), v16, exp16);
            val = 16'((n + 1) / (d + 1));
            if (dir) val = 16'(0) - val;
            exp16 = to_gray(val);
            check($sformatf("rcnt_uo_out_%0d", it), uo_out, exp16[7:0]);
            wr(A_CTRL, C_CLEAR);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
